// File: rtl/multicycle_main_control_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset main control.
package multicycle_main_control_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    R_WB     = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WB   = 4'd7,
    MEM_WR   = 4'd8,
    BRANCH   = 4'd9,
    TRAP     = 4'd10
  } state_t;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef struct packed {
    logic is_r;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_bad;
  } opc_class_t;

endpackage

// File: rtl/multicycle_main_control_if.sv
// Unified-memory request/acknowledge handshake between control and memory.
interface multicycle_main_control_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output iord, input mem_ack);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ack);
endinterface

// File: rtl/multicycle_main_control_opcode_classifier.sv
// Combinational opcode decode into a one-hot instruction class.
module opcode_classifier
  import multicycle_main_control_pkg::*;
(
  input  logic [6:0] i_opcode,
  output opc_class_t o_class
);

  // One-hot class; anything outside the supported subset is flagged bad
  always_comb begin
    o_class = '{is_r: 1'b0, is_lw: 1'b0, is_sw: 1'b0, is_beq: 1'b0, is_bad: 1'b0};
    case (i_opcode)
      OPC_R:   o_class.is_r   = 1'b1;
      OPC_LW:  o_class.is_lw  = 1'b1;
      OPC_SW:  o_class.is_sw  = 1'b1;
      OPC_BEQ: o_class.is_beq = 1'b1;
      default: o_class.is_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and counts retired instructions.
module multicycle_main_control
  import multicycle_main_control_pkg::*;
#(
  parameter int width_instruc = 32,
  parameter int CNT_W         = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic [width_instruc-1:0] instr,
  input  logic                     zero,
  multicycle_main_control_if.master mem,
  output logic                     ir_write,
  output logic                     pc_write,
  output logic                     pc_write_cond,
  output logic                     pc_source,
  output logic                     alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic [1:0]               ALU_OP,
  output logic                     reg_write,
  output logic                     mem_to_reg,
  output logic                     busy,
  output logic                     illegal,
  output logic [CNT_W-1:0]         retired
);

  state_t           r_state;
  state_t           w_next;
  state_t           w_after_retire;
  logic             r_ack_d;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;
  opc_class_t       w_cls;
  logic             w_req_raw;
  logic             w_we;
  logic             w_iord;
  logic             w_ack;
  logic             w_retire;
  logic             w_unused;

  opcode_classifier u_classifier (
    .i_opcode (instr[6:0]),
    .o_class  (w_cls)
  );

  // zero is consumed by the datapath through pc_write_cond, not by the FSM
  assign w_unused       = ^{instr[width_instruc-1:7], zero};
  assign mem.mem_req    = w_req_raw & ~r_ack_d;
  assign mem.mem_we     = w_we;
  assign mem.iord       = w_iord;
  assign w_ack          = mem.mem_req & mem.mem_ack;
  assign w_after_retire = run ? FETCH : IDLE;
  assign illegal        = r_illegal;
  assign retired        = r_retired;

  // State register plus one-cycle memory of a completed handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ack_d <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ack_d <= w_ack;
    end
  end

  // Next-state logic; run is only consulted in IDLE and on retire
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      IDLE:     w_next = run ? FETCH : IDLE;
      FETCH:    w_next = w_ack ? DECODE : FETCH;
      DECODE: begin
        if (w_cls.is_r) begin
          w_next = EXEC_R;
        end else if (w_cls.is_lw || w_cls.is_sw) begin
          w_next = MEM_ADDR;
        end else if (w_cls.is_beq) begin
          w_next = BRANCH;
        end else begin
          w_next = TRAP;
        end
      end
      EXEC_R:   w_next = R_WB;
      MEM_ADDR: w_next = w_cls.is_lw ? MEM_RD : MEM_WR;
      MEM_RD:   w_next = w_ack ? MEM_WB : MEM_RD;
      R_WB, MEM_WB, BRANCH: begin
        w_retire = 1'b1;
        w_next   = w_after_retire;
      end
      MEM_WR: begin
        w_retire = w_ack;
        w_next   = w_ack ? w_after_retire : MEM_WR;
      end
      TRAP:     w_next = TRAP;
      default:  w_next = IDLE;
    endcase
  end

  // Moore output decode; only the fetch load strobes follow the ack
  always_comb begin
    w_req_raw     = 1'b0;
    w_we          = 1'b0;
    w_iord        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RS2;
    ALU_OP        = ALUOP_ADD;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    busy          = (r_state != IDLE);
    case (r_state)
      FETCH: begin
        w_req_raw = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = w_ack;
        pc_write  = w_ack;
      end
      DECODE:   alu_src_b = SRCB_IMM;
      EXEC_R: begin
        alu_src_a = 1'b1;
        ALU_OP    = ALUOP_FUNCT;
      end
      R_WB:     reg_write = 1'b1;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        w_req_raw = 1'b1;
        w_iord    = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        w_req_raw = 1'b1;
        w_iord    = 1'b1;
        w_we      = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        ALU_OP        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
      end
      default: busy = (r_state != IDLE);
    endcase
  end

  // Retired counter (free-running wrap) and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_retired <= w_retire ? r_retired + CNT_W'(1) : r_retired;
      r_illegal <= r_illegal | (w_next == TRAP);
    end
  end

endmodule
